// File: rtl/pe_seq.sv
// PE job sequencer: streams kernels and 5x5 windows from SRAM into the PE,
// then steps output channels and writes psums (optionally accumulated).
module pe_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  start,
  input  logic [4:0]            cfg_num_knls,
  input  logic [5:0]            cfg_ifmap_w,
  input  logic [5:0]            cfg_ifmap_h,
  input  logic [ADDR_WIDTH-1:0] cfg_knl_base,
  input  logic [ADDR_WIDTH-1:0] cfg_ifmap_base,
  input  logic [ADDR_WIDTH-1:0] cfg_ofmap_base,
  input  logic                  cfg_acc,
  output logic                  busy,
  output logic                  done,
  output logic                  src_rd_en,
  output logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0] src_rdata,
  output logic                  ofm_rd_en,
  output logic [ADDR_WIDTH-1:0] ofm_rd_addr,
  input  logic [DATA_WIDTH-1:0] ofm_rdata,
  output logic                  ofm_wr_en,
  output logic [ADDR_WIDTH-1:0] ofm_wr_addr,
  output logic [DATA_WIDTH-1:0] ofm_wr_data,
  output logic [DATA_WIDTH-1:0] pe_data_in,
  input  logic [DATA_WIDTH-1:0] pe_data_out,
  output logic                  en_ld_knl,
  output logic                  en_ld_ifmap,
  output logic                  disable_acc,
  output logic [5:0]            num_knls,
  output logic [4:0]            cnt_ofmap_chnl
);

  typedef enum logic [2:0] {
    IDLE, LD_KNL, LD_WIN, WAIT, COMP, DRAIN
  } state_t;

  state_t state;

  logic [4:0]            n_q;
  logic [5:0]            w_q, h_q;
  logic [ADDR_WIDTH-1:0] ib_q, ob_q;
  logic                  acc_q;
  logic [8:0]            kcnt;
  logic [2:0]            wrow, wcol;
  logic [5:0]            r, c;
  logic                  dcnt;
  logic                  p1_vld;
  logic [ADDR_WIDTH-1:0] p1_addr;

  logic [8:0]            knl_last;
  logic [5:0]            r_last, c_last, nr, nc;
  logic                  last_c, last_pos;
  logic [2:0]            nrow, ncol;
  logic [ADDR_WIDTH-1:0] ow, plane, wr_addr_c;

  assign knl_last  = 9'(n_q) * 9'd25 - 9'd1;
  assign r_last    = h_q - 6'd5;
  assign c_last    = w_q - 6'd5;
  assign last_c    = (c == c_last);
  assign last_pos  = last_c && (r == r_last);
  assign nc        = last_c ? 6'd0 : c + 6'd1;
  assign nr        = last_c ? r + 6'd1 : r;
  assign nrow      = (wrow == 3'd4) ? 3'd0 : wrow + 3'd1;
  assign ncol      = (wrow == 3'd4) ? wcol + 3'd1 : wcol;
  assign ow        = ADDR_WIDTH'(w_q - 6'd4);
  assign plane     = ADDR_WIDTH'(h_q - 6'd4) * ow;
  assign wr_addr_c = ob_q + ADDR_WIDTH'(cnt_ofmap_chnl) * plane
                   + ADDR_WIDTH'(r) * ow + ADDR_WIDTH'(c);

  function automatic logic [ADDR_WIDTH-1:0] waddr(
    input logic [5:0] pr,
    input logic [5:0] pc,
    input logic [2:0] row,
    input logic [2:0] col
  );
    return ib_q + (ADDR_WIDTH'(pr) + ADDR_WIDTH'(row)) * ADDR_WIDTH'(w_q)
         + ADDR_WIDTH'(pc) + ADDR_WIDTH'(col);
  endfunction

  // Returned psum feeds the PE only in the writeback cycle of an acc job
  assign pe_data_in = (ofm_wr_en && acc_q) ? ofm_rdata :
                      (en_ld_knl || en_ld_ifmap) ? src_rdata : '0;
  assign ofm_wr_data = ofm_wr_en ? pe_data_out : '0;

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      src_rd_en      <= 1'b0;
      src_addr       <= '0;
      ofm_rd_en      <= 1'b0;
      ofm_rd_addr    <= '0;
      ofm_wr_en      <= 1'b0;
      ofm_wr_addr    <= '0;
      en_ld_knl      <= 1'b0;
      en_ld_ifmap    <= 1'b0;
      disable_acc    <= 1'b1;
      num_knls       <= '0;
      cnt_ofmap_chnl <= '0;
      n_q            <= '0;
      w_q            <= '0;
      h_q            <= '0;
      ib_q           <= '0;
      ob_q           <= '0;
      acc_q          <= 1'b0;
      kcnt           <= '0;
      wrow           <= '0;
      wcol           <= '0;
      r              <= '0;
      c              <= '0;
      dcnt           <= 1'b0;
      p1_vld         <= 1'b0;
      p1_addr        <= '0;
    end else begin
      done        <= 1'b0;
      en_ld_knl   <= src_rd_en && (state == LD_KNL);
      en_ld_ifmap <= src_rd_en && (state == LD_WIN);
      p1_vld      <= (state == COMP);
      p1_addr     <= wr_addr_c;
      ofm_rd_en   <= (state == COMP) && acc_q;
      ofm_rd_addr <= ((state == COMP) && acc_q) ? wr_addr_c : '0;
      ofm_wr_en   <= p1_vld;
      ofm_wr_addr <= p1_vld ? p1_addr : '0;
      unique case (state)
        IDLE: begin
          if (start) begin
            n_q         <= cfg_num_knls;
            w_q         <= cfg_ifmap_w;
            h_q         <= cfg_ifmap_h;
            ib_q        <= cfg_ifmap_base;
            ob_q        <= cfg_ofmap_base;
            acc_q       <= cfg_acc;
            busy        <= 1'b1;
            disable_acc <= ~cfg_acc;
            num_knls    <= {1'b0, cfg_num_knls};
            src_rd_en   <= 1'b1;
            src_addr    <= cfg_knl_base;
            kcnt        <= '0;
            r           <= '0;
            c           <= '0;
            state       <= LD_KNL;
          end
        end
        LD_KNL: begin
          if (kcnt == knl_last) begin
            src_addr <= ib_q;
            wrow     <= '0;
            wcol     <= '0;
            state    <= LD_WIN;
          end else begin
            kcnt     <= kcnt + 9'd1;
            src_addr <= src_addr + 1'b1;
          end
        end
        LD_WIN: begin
          if (wrow == 3'd4 && wcol == 3'd4) begin
            src_rd_en <= 1'b0;
            src_addr  <= '0;
            state     <= WAIT;
          end else begin
            wrow     <= nrow;
            wcol     <= ncol;
            src_addr <= waddr(r, c, nrow, ncol);
          end
        end
        WAIT: begin
          cnt_ofmap_chnl <= '0;
          state          <= COMP;
        end
        COMP: begin
          if (cnt_ofmap_chnl == n_q - 5'd1) begin
            cnt_ofmap_chnl <= '0;
            dcnt           <= 1'b0;
            state          <= DRAIN;
          end else begin
            cnt_ofmap_chnl <= cnt_ofmap_chnl + 5'd1;
          end
        end
        DRAIN: begin
          if (!dcnt) begin
            dcnt <= 1'b1;
          end else if (last_pos) begin
            busy        <= 1'b0;
            done        <= 1'b1;
            disable_acc <= 1'b1;
            num_knls    <= '0;
            state       <= IDLE;
          end else begin
            r         <= nr;
            c         <= nc;
            wrow      <= '0;
            wcol      <= '0;
            src_rd_en <= 1'b1;
            src_addr  <= waddr(nr, nc, 3'd0, 3'd0);
            state     <= LD_WIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_seq.sv
// Bench for pe_seq: SRAM and PE behavioural models, a write scoreboard
// fed at job issue and drained by a monitor on each ofmap write.
module tb_pe_seq;

  localparam int DW = 32;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          srstn, start;
  logic [4:0]    cfg_num_knls;
  logic [5:0]    cfg_ifmap_w, cfg_ifmap_h;
  logic [AW-1:0] cfg_knl_base, cfg_ifmap_base, cfg_ofmap_base;
  logic          cfg_acc;
  logic          busy, done;
  logic          src_rd_en;
  logic [AW-1:0] src_addr;
  logic [DW-1:0] src_rdata;
  logic          ofm_rd_en;
  logic [AW-1:0] ofm_rd_addr;
  logic [DW-1:0] ofm_rdata;
  logic          ofm_wr_en;
  logic [AW-1:0] ofm_wr_addr;
  logic [DW-1:0] ofm_wr_data;
  logic [DW-1:0] pe_data_in, pe_data_out;
  logic          en_ld_knl, en_ld_ifmap, disable_acc;
  logic [5:0]    num_knls;
  logic [4:0]    cnt_ofmap_chnl;

  always #5 clk = ~clk;

  pe_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .srstn(srstn), .start(start),
    .cfg_num_knls(cfg_num_knls),
    .cfg_ifmap_w(cfg_ifmap_w), .cfg_ifmap_h(cfg_ifmap_h),
    .cfg_knl_base(cfg_knl_base), .cfg_ifmap_base(cfg_ifmap_base),
    .cfg_ofmap_base(cfg_ofmap_base), .cfg_acc(cfg_acc),
    .busy(busy), .done(done),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rdata(src_rdata),
    .ofm_rd_en(ofm_rd_en), .ofm_rd_addr(ofm_rd_addr),
    .ofm_rdata(ofm_rdata),
    .ofm_wr_en(ofm_wr_en), .ofm_wr_addr(ofm_wr_addr),
    .ofm_wr_data(ofm_wr_data),
    .pe_data_in(pe_data_in), .pe_data_out(pe_data_out),
    .en_ld_knl(en_ld_knl), .en_ld_ifmap(en_ld_ifmap),
    .disable_acc(disable_acc), .num_knls(num_knls),
    .cnt_ofmap_chnl(cnt_ofmap_chnl)
  );

  logic [31:0] smem [0:4095];
  logic [31:0] omem [0:4095];

  always @(posedge clk) begin
    if (src_rd_en) src_rdata <= smem[src_addr[11:0]];
    if (ofm_rd_en) ofm_rdata <= omem[ofm_rd_addr[11:0]];
    if (ofm_wr_en) omem[ofm_wr_addr[11:0]] = ofm_wr_data;
  end

  function automatic logic [31:0] q16(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[47:16];
  endfunction

  // PE model: kernels and window stored in load order, 2-cycle MAC
  logic [31:0] kbuf [0:399];
  logic [31:0] win [0:24];
  int          kidx = 0, widx = 0;
  logic [31:0] st1 = 0, st2 = 0;

  function automatic logic [31:0] pe_mac(input int ch);
    logic [31:0] s;
    s = 0;
    if (ch < 16)
      for (int j = 0; j < 25; j++) s = s + q16(kbuf[ch*25+j], win[j]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (en_ld_knl && kidx < 400) kbuf[kidx] <= pe_data_in;
    if (en_ld_ifmap) win[widx] <= pe_data_in;
    if (!busy) begin
      kidx <= 0;
      widx <= 0;
    end else begin
      if (en_ld_knl) kidx <= kidx + 1;
      if (en_ld_ifmap) widx <= (widx == 24) ? 0 : widx + 1;
    end
    st1 <= pe_mac(int'(cnt_ofmap_chnl));
    st2 <= st1;
  end

  assign pe_data_out = st2 + (disable_acc ? 32'd0 : pe_data_in);

  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0, errors = 0;
  logic [AW-1:0] exp_addr_q [$];
  logic [31:0]   exp_data_q [$];
  logic [AW-1:0] rd_log [$];
  bit            acc_mode = 0;
  int            n_knl = 0, n_wr = 0, n_rd = 0, rd_bad = 0, viol = 0, n_acc = 0;
  logic [AW-1:0] last_wr = 0, prev_rd_addr = 0;
  logic          prev_rd = 0;

  always @(negedge clk) begin
    logic [AW-1:0] ea;
    logic [31:0]   ed;
    if (en_ld_knl) n_knl++;
    if (src_rd_en) rd_log.push_back(src_addr);
    if (src_rd_en || ofm_rd_en || ofm_wr_en) n_acc++;
    if ((en_ld_knl && en_ld_ifmap) || (en_ld_ifmap && ofm_wr_en)) viol++;
    if (ofm_rd_en) n_rd++;
    if (ofm_wr_en) begin
      n_wr++;
      last_wr = ofm_wr_addr;
      if (acc_mode && !(prev_rd && prev_rd_addr == ofm_wr_addr)) rd_bad++;
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, no write expected",
                 ofm_wr_addr, ofm_wr_data);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        if (ofm_wr_addr !== ea || ofm_wr_data !== ed) begin
          errors++;
          $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                   ofm_wr_addr, ofm_wr_data, ea, ed);
        end
      end
    end
    prev_rd      = ofm_rd_en;
    prev_rd_addr = ofm_rd_addr;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, 64'({busy, done, src_rd_en, ofm_rd_en, ofm_wr_en,
                            en_ld_knl, en_ld_ifmap, disable_acc}), 64'h1);
    chk({tag, "_addr"}, 64'({src_addr, ofm_rd_addr, ofm_wr_addr}), 64'h0);
    chk({tag, "_data"}, {pe_data_in, ofm_wr_data}, 64'h0);
    chk({tag, "_chnl"}, 64'({cnt_ofmap_chnl, num_knls}), 64'h0);
  endtask

  function automatic logic [31:0] ref_mac(input int kb, input int ib, input int w,
                                          input int ch, input int r, input int c);
    logic [31:0] s;
    s = 0;
    for (int col = 0; col < 5; col++)
      for (int row = 0; row < 5; row++)
        s = s + q16(smem[(kb + ch*25 + col*5 + row) & 4095],
                    smem[(ib + (r+row)*w + c + col) & 4095]);
    return s;
  endfunction

  task automatic push_exp(input int n, input int w, input int h, input int kb,
                          input int ib, input int ob, input bit acc, input int npos);
    int            k;
    logic [AW-1:0] a;
    logic [31:0]   d;
    k = 0;
    for (int r = 0; r <= h - 5; r++)
      for (int c = 0; c <= w - 5; c++) begin
        if (k < npos)
          for (int ch = 0; ch < n; ch++) begin
            a = AW'(ob + ch*(h-4)*(w-4) + r*(w-4) + c);
            d = ref_mac(kb, ib, w, ch, r, c);
            if (acc) d = d + omem[a[11:0]];
            exp_addr_q.push_back(a);
            exp_data_q.push_back(d);
          end
        k++;
      end
  endtask

  task automatic set_cfg(input int n, input int w, input int h, input int kb,
                         input int ib, input int ob, input bit acc);
    cfg_num_knls   = 5'(n);
    cfg_ifmap_w    = 6'(w);
    cfg_ifmap_h    = 6'(h);
    cfg_knl_base   = AW'(kb);
    cfg_ifmap_base = AW'(ib);
    cfg_ofmap_base = AW'(ob);
    cfg_acc        = acc;
  endtask

  int job_log0 = 0;

  task automatic run_job(input int n, input int w, input int h, input int kb,
                         input int ib, input int ob, input bit acc,
                         input int exp_len, input int pulse_at);
    int  c0, knl0, wr0, rd0, bad0, v0, p, len;
    bit  got;
    p = (h-4) * (w-4);
    acc_mode = acc;
    push_exp(n, w, h, kb, ib, ob, acc, p);
    knl0 = n_knl; wr0 = n_wr; rd0 = n_rd; bad0 = rd_bad; v0 = viol;
    job_log0 = rd_log.size();
    set_cfg(n, w, h, kb, ib, ob, acc);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c0 = cyc;
    chk("busy_rise", 64'(busy), 64'h1);
    chk("disable_acc_busy", 64'(disable_acc), 64'(!acc));
    chk("num_knls", 64'(num_knls), 64'(n));
    got = 0;
    for (int i = 0; i < exp_len + 50; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      start = (pulse_at > 0 && (cyc - c0 + 1) == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
    len = cyc - c0 + 1;
    chk("done_seen", 64'(got), 64'h1);
    chk("job_length", 64'(len), 64'(exp_len));
    chk("knl_loads", 64'(n_knl - knl0), 64'(25*n));
    chk("src_reads", 64'(rd_log.size() - job_log0), 64'(25*n + 25*p));
    chk("write_count", 64'(n_wr - wr0), 64'(n*p));
    chk("rd_count", 64'(n_rd - rd0), acc ? 64'(n*p) : 64'h0);
    chk("rd_before_wr", 64'(rd_bad - bad0), 64'h0);
    chk("enable_overlap", 64'(viol - v0), 64'h0);
    chk("sb_drained", 64'(exp_addr_q.size()), 64'h0);
    @(negedge clk);
    chk("done_pulse", 64'({done, busy, disable_acc}), 64'h1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] wexp [6];
    int c0, a0;
    srstn = 1'b0;
    start = 1'b0;
    set_cfg(1, 5, 5, 0, 0, 0, 0);
    for (int i = 0; i < 4096; i++) begin
      smem[i] = 0;
      omem[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk_idle("reset");
    srstn = 1'b1;
    @(negedge clk);
    chk_idle("idle");

    // single position, uniform data: 25 * (1.0 * 2.0) = 50.0
    for (int i = 0; i < 25; i++) begin
      smem['h100 + i] = 32'h0001_0000;
      smem['h800 + i] = 32'h0002_0000;
    end
    run_job(1, 5, 5, 'h100, 'h800, 'h200, 0, 55, 0);
    chk("mac_uniform", 64'(omem['h200]), 64'h0032_0000);

    for (int i = 0; i < 4096; i++) smem[i] = 32'(((i*5) % 13 + 1) << 16);

    run_job(16, 6, 6, 'h100, 'h800, 'h300, 0, 577, 0);
    chk("last_write_addr", 64'(last_wr), 64'h33F);

    run_job(1, 7, 5, 'h100, 'h800, 'h200, 0, 113, 0);
    wexp = '{18'h802, 18'h809, 18'h810, 18'h817, 18'h81E, 18'h803};
    for (int i = 0; i < 6; i++)
      if (job_log0 + 75 + i < rd_log.size())
        chk("window_order", 64'(rd_log[job_log0 + 75 + i]), 64'(wexp[i]));
      else
        chk("window_order_len", 64'(rd_log.size()), 64'(job_log0 + 81));

    for (int i = 0; i < 8; i++) omem['h400 + i] = 32'h0001_0000;
    run_job(3, 6, 5, 'h100, 'h800, 'h400, 1, 138, 0);

    run_job(2, 6, 6, 'h100, 'h800, 'h600, 0, 171, 40);

    run_job(1, 6, 6, 'h100, 'h800, 'h3FFFE, 0, 142, 0);
    chk("wrap_last_addr", 64'(last_wr), 64'h1);

    // abort in the first COMP cycle of the third position
    acc_mode = 0;
    push_exp(2, 6, 6, 'h100, 'h800, 'h500, 0, 2);
    set_cfg(2, 6, 6, 'h100, 'h800, 'h500, 0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 200 && (cyc - c0 + 1) < 137; i++) @(negedge clk);
    chk("abort_point", 64'(cyc - c0 + 1), 64'd137);
    srstn = 1'b0;
    @(negedge clk);
    chk_idle("abort");
    srstn = 1'b1;
    a0 = n_acc;
    repeat (10) @(negedge clk);
    chk("abort_no_access", 64'(n_acc - a0), 64'h0);
    chk("abort_sb_drained", 64'(exp_addr_q.size()), 64'h0);
    run_job(2, 6, 6, 'h100, 'h800, 'h500, 0, 171, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
